// File: rtl/mem_bus_arbiter_pkg.sv
// +------------------------------------------------------------------+
// | mem_bus_arbiter_pkg                                              |
// | Shared FSM state encoding and port indices for the bus arbiter.  |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

package mem_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ACCESS  = 2'd1,
    S_RESPOND = 2'd2
  } arb_state_t;

  localparam logic ARB_PORT_CORE = 1'b0;
  localparam logic ARB_PORT_DMA  = 1'b1;

  // Only word-aligned accesses reach the memory.
  function automatic logic is_misaligned(input logic [1:0] addr_lsbs);
    return addr_lsbs != 2'b00;
  endfunction

endpackage

`default_nettype wire

// File: rtl/dff_reg.sv
// +------------------------------------------------------------------+
// | dff_reg                                                          |
// | Parameterized enable register with synchronous reset value.      |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

module dff_reg #(
  parameter int unsigned     WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= RESET_VAL;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/rr_pick2.sv
// +------------------------------------------------------------------+
// | rr_pick2                                                         |
// | Two-way round-robin pick: one-hot grant from req and last_grant. |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

module rr_pick2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = req;
    // On contention the port that did not win last time goes first.
    if (req == 2'b11) begin
      gnt = last_grant ? 2'b01 : 2'b10;
    end
  end

endmodule

`default_nettype wire

// File: rtl/mem_bus_arbiter.sv
// +------------------------------------------------------------------+
// | mem_bus_arbiter                                                  |
// | Two-port (core / DMA) arbiter onto a registered single memory.   |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int unsigned FIRST_PRIORITY = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        p0_req,
  input  logic        p1_req,
  input  logic [31:0] p0_addr,
  input  logic [31:0] p1_addr,
  input  logic [31:0] p0_wr_data,
  input  logic [31:0] p1_wr_data,
  input  logic        p0_wr_ena,
  input  logic        p1_wr_ena,
  output logic        p0_gnt,
  output logic        p1_gnt,
  output logic        p0_done,
  output logic        p1_done,
  output logic        p0_err,
  output logic        p1_err,
  output logic [31:0] p0_rd_data,
  output logic [31:0] p1_rd_data,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wr_data,
  output logic        mem_wr_ena,
  input  logic [31:0] mem_rd_data,
  output logic [31:0] xfer_count
);

  localparam logic C_FIRST = FIRST_PRIORITY[0];

  arb_state_t  r_state;
  arb_state_t  w_state_next;
  logic [1:0]  w_req;
  logic [1:0]  w_pick;
  logic        w_grant;
  logic        w_win;
  logic [65:0] w_pay_d;
  logic [65:0] r_pay_q;
  logic        r_win;
  logic        r_wr_ena;
  logic [31:0] r_addr;
  logic [31:0] r_wr_data;
  logic        r_last_grant;
  logic        w_misaligned;
  logic        w_respond;
  logic        w_rd_ok;
  logic [31:0] r_rd_data0;
  logic [31:0] r_rd_data1;
  logic [31:0] r_xfer_count;

  // Requests are only seen in S_IDLE and never while reset is asserted.
  assign w_req   = (r_state == S_IDLE && !rst) ? {p1_req, p0_req} : 2'b00;
  assign w_grant = |w_pick;
  assign w_win   = w_pick[ARB_PORT_DMA];
  assign p0_gnt  = w_pick[ARB_PORT_CORE];
  assign p1_gnt  = w_pick[ARB_PORT_DMA];

  rr_pick2 u_pick (
    .req        (w_req),
    .last_grant (r_last_grant),
    .gnt        (w_pick)
  );

  assign w_pay_d = w_win ? {1'b1, p1_addr, p1_wr_ena, p1_wr_data}
                         : {1'b0, p0_addr, p0_wr_ena, p0_wr_data};

  dff_reg #(.WIDTH(66)) u_payload (
    .clk (clk),
    .rst (rst),
    .en  (w_grant),
    .d   (w_pay_d),
    .q   (r_pay_q)
  );

  dff_reg #(.WIDTH(1), .RESET_VAL(~C_FIRST)) u_last_grant (
    .clk (clk),
    .rst (rst),
    .en  (w_grant),
    .d   (w_win),
    .q   (r_last_grant)
  );

  assign {r_win, r_addr, r_wr_ena, r_wr_data} = r_pay_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:    if (w_grant) w_state_next = S_ACCESS;
      S_ACCESS:  w_state_next = S_RESPOND;
      S_RESPOND: w_state_next = S_IDLE;
      default:   w_state_next = S_IDLE;
    endcase
  end

  assign w_misaligned = is_misaligned(r_addr[1:0]);
  assign mem_addr     = r_addr;
  assign mem_wr_data  = r_wr_data;
  assign mem_wr_ena   = (r_state == S_ACCESS) && !rst && r_wr_ena && !w_misaligned;

  assign w_respond = (r_state == S_RESPOND) && !rst;
  assign w_rd_ok   = w_respond && !r_wr_ena && !w_misaligned;
  assign p0_done   = w_respond && (r_win == ARB_PORT_CORE);
  assign p1_done   = w_respond && (r_win == ARB_PORT_DMA);
  assign p0_err    = p0_done && w_misaligned;
  assign p1_err    = p1_done && w_misaligned;

  // Read data is forwarded during done and then held until the next read.
  assign p0_rd_data = (w_rd_ok && r_win == ARB_PORT_CORE) ? mem_rd_data : r_rd_data0;
  assign p1_rd_data = (w_rd_ok && r_win == ARB_PORT_DMA)  ? mem_rd_data : r_rd_data1;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_data0   <= '0;
      r_rd_data1   <= '0;
      r_xfer_count <= '0;
    end else begin
      if (w_rd_ok && r_win == ARB_PORT_CORE) r_rd_data0 <= mem_rd_data;
      if (w_rd_ok && r_win == ARB_PORT_DMA)  r_rd_data1 <= mem_rd_data;
      if (w_respond) r_xfer_count <= r_xfer_count + 32'd1;
    end
  end

  assign xfer_count = r_xfer_count;

endmodule

`default_nettype wire

// File: tb/tb_mem_bus_arbiter.sv
// +------------------------------------------------------------------+
// | tb_mem_bus_arbiter                                               |
// | Directed self-checking bench for mem_bus_arbiter.                |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

module tb_mem_bus_arbiter;
  import mem_bus_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        p0_req = 1'b0, p1_req = 1'b0;
  logic [31:0] p0_addr = '0, p1_addr = '0, p0_wr_data = '0, p1_wr_data = '0;
  logic        p0_wr_ena = 1'b0, p1_wr_ena = 1'b0;
  logic        p0_gnt, p1_gnt, p0_done, p1_done, p0_err, p1_err;
  logic [31:0] p0_rd_data, p1_rd_data, mem_addr, mem_wr_data, xfer_count;
  logic        mem_wr_ena;
  logic [31:0] mem_rd_data = '0;
  logic [31:0] rd_value = '0;

  int checks = 0;
  int failures = 0;

  mem_bus_arbiter #(.FIRST_PRIORITY(0)) dut (
    .clk (clk), .rst (rst),
    .p0_req (p0_req), .p1_req (p1_req),
    .p0_addr (p0_addr), .p1_addr (p1_addr),
    .p0_wr_data (p0_wr_data), .p1_wr_data (p1_wr_data),
    .p0_wr_ena (p0_wr_ena), .p1_wr_ena (p1_wr_ena),
    .p0_gnt (p0_gnt), .p1_gnt (p1_gnt),
    .p0_done (p0_done), .p1_done (p1_done),
    .p0_err (p0_err), .p1_err (p1_err),
    .p0_rd_data (p0_rd_data), .p1_rd_data (p1_rd_data),
    .mem_addr (mem_addr), .mem_wr_data (mem_wr_data), .mem_wr_ena (mem_wr_ena),
    .mem_rd_data (mem_rd_data), .xfer_count (xfer_count)
  );

  always #5 clk = ~clk;

  // Registered memory: data appears one cycle after the address.
  always @(posedge clk) mem_rd_data <= rd_value;

  task automatic test_reset();
    rst = 1'b1; p0_req = 1'b1; p1_req = 1'b1; p0_addr = 32'h10; p1_addr = 32'h20;
    @(negedge clk); @(negedge clk);
    checks++; if ({p1_gnt, p0_gnt} !== 2'b00) begin failures++; $display("FAIL reset_gnt got=%b exp=00", {p1_gnt, p0_gnt}); end
    checks++; if ({p1_done, p0_done, p1_err, p0_err, mem_wr_ena} !== 5'b0) begin failures++; $display("FAIL reset_flags got=%b exp=00000", {p1_done, p0_done, p1_err, p0_err, mem_wr_ena}); end
    checks++; if (xfer_count !== 32'h0) begin failures++; $display("FAIL reset_xfer got=%h exp=0", xfer_count); end
    checks++; if ({mem_addr, mem_wr_data} !== 64'h0) begin failures++; $display("FAIL reset_mem got=%h/%h exp=0/0", mem_addr, mem_wr_data); end
    checks++; if ({p0_rd_data, p1_rd_data} !== 64'h0) begin failures++; $display("FAIL reset_rd got=%h/%h exp=0/0", p0_rd_data, p1_rd_data); end
    p0_req = 1'b0; p1_req = 1'b0; rst = 1'b0;
  endtask

  task automatic test_single_read();
    @(negedge clk);
    p0_addr = 32'h10; p0_wr_ena = 1'b0; p0_req = 1'b1; rd_value = 32'hDEADBEEF; #1;
    checks++; if ({p1_gnt, p0_gnt} !== 2'b01) begin failures++; $display("FAIL read_gnt got=%b exp=01", {p1_gnt, p0_gnt}); end
    @(negedge clk);
    checks++; if (mem_addr !== 32'h10 || mem_wr_ena !== 1'b0) begin failures++; $display("FAIL read_access got=%h/%b exp=00000010/0", mem_addr, mem_wr_ena); end
    checks++; if ({p1_gnt, p0_gnt} !== 2'b00) begin failures++; $display("FAIL read_no_gnt_access got=%b exp=00", {p1_gnt, p0_gnt}); end
    p0_req = 1'b0;
    @(negedge clk);
    checks++; if ({p1_done, p0_done, p0_err} !== 3'b010) begin failures++; $display("FAIL read_done got=%b exp=010", {p1_done, p0_done, p0_err}); end
    checks++; if (p0_rd_data !== 32'hDEADBEEF) begin failures++; $display("FAIL read_data got=%h exp=deadbeef", p0_rd_data); end
    @(negedge clk);
    checks++; if (xfer_count !== 32'd1 || p0_done !== 1'b0) begin failures++; $display("FAIL read_after got=%h/%b exp=1/0", xfer_count, p0_done); end
    checks++; if (p0_rd_data !== 32'hDEADBEEF) begin failures++; $display("FAIL read_hold got=%h exp=deadbeef", p0_rd_data); end
  endtask

  task automatic test_single_write();
    @(negedge clk);
    p1_addr = 32'h20; p1_wr_data = 32'hCAFEF00D; p1_wr_ena = 1'b1; p1_req = 1'b1; #1;
    checks++; if ({p1_gnt, p0_gnt} !== 2'b10) begin failures++; $display("FAIL write_gnt got=%b exp=10", {p1_gnt, p0_gnt}); end
    @(negedge clk);
    checks++; if (mem_wr_ena !== 1'b1 || mem_wr_data !== 32'hCAFEF00D || mem_addr !== 32'h20) begin
      failures++; $display("FAIL write_access got=%b/%h/%h exp=1/cafef00d/00000020", mem_wr_ena, mem_wr_data, mem_addr); end
    p1_req = 1'b0; p1_wr_ena = 1'b0;
    @(negedge clk);
    checks++; if (mem_wr_ena !== 1'b0) begin failures++; $display("FAIL write_one_cycle got=%b exp=0", mem_wr_ena); end
    checks++; if ({p1_done, p1_err, p0_done, p0_err} !== 4'b1000) begin failures++; $display("FAIL write_done got=%b exp=1000", {p1_done, p1_err, p0_done, p0_err}); end
    checks++; if (p0_rd_data !== 32'hDEADBEEF || p1_rd_data !== 32'h0) begin failures++; $display("FAIL write_rd_unchanged got=%h/%h exp=deadbeef/0", p0_rd_data, p1_rd_data); end
    @(negedge clk);
    checks++; if (xfer_count !== 32'd2) begin failures++; $display("FAIL write_xfer got=%h exp=2", xfer_count); end
  endtask

  task automatic test_contention();
    logic [1:0] exp_gnt;
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    rd_value = 32'h11111111;
    p0_addr = 32'h40; p0_wr_ena = 1'b0; p1_addr = 32'h44; p1_wr_ena = 1'b0;
    p0_req = 1'b1; p1_req = 1'b1; #1;
    for (int c = 0; c < 12; c++) begin
      if (c > 0) @(negedge clk);
      exp_gnt = (c % 3 != 0) ? 2'b00 : (((c / 3) % 2 == 1) ? 2'b10 : 2'b01);
      checks++; if ({p1_gnt, p0_gnt} !== exp_gnt) begin failures++; $display("FAIL contention_c%0d got=%b exp=%b", c, {p1_gnt, p0_gnt}, exp_gnt); end
      if (c == 11) begin p0_req = 1'b0; p1_req = 1'b0; end
    end
    @(negedge clk);
    checks++; if (xfer_count !== 32'd4) begin failures++; $display("FAIL contention_xfer got=%h exp=4", xfer_count); end
  endtask

  task automatic test_misaligned();
    @(negedge clk);
    p0_addr = 32'h13; p0_wr_data = 32'h12345678; p0_wr_ena = 1'b1; p0_req = 1'b1; #1;
    checks++; if ({p1_gnt, p0_gnt} !== 2'b01) begin failures++; $display("FAIL misal_gnt got=%b exp=01", {p1_gnt, p0_gnt}); end
    @(negedge clk);
    checks++; if (mem_wr_ena !== 1'b0) begin failures++; $display("FAIL misal_wr_ena got=%b exp=0", mem_wr_ena); end
    p0_req = 1'b0; p0_wr_ena = 1'b0;
    @(negedge clk);
    checks++; if ({p0_done, p0_err, p1_done, p1_err} !== 4'b1100) begin failures++; $display("FAIL misal_done_err got=%b exp=1100", {p0_done, p0_err, p1_done, p1_err}); end
    @(negedge clk);
    checks++; if (xfer_count !== 32'd5) begin failures++; $display("FAIL misal_xfer got=%h exp=5", xfer_count); end
    p0_addr = 32'h15; rd_value = 32'h55555555; p0_req = 1'b1; #1;
    @(negedge clk); p0_req = 1'b0;
    @(negedge clk);
    checks++; if ({p0_done, p0_err} !== 2'b11 || p0_rd_data !== 32'h11111111) begin
      failures++; $display("FAIL misal_read got=%b/%h exp=11/11111111", {p0_done, p0_err}, p0_rd_data); end
    @(negedge clk);
    checks++; if (p0_rd_data !== 32'h11111111 || xfer_count !== 32'd6) begin
      failures++; $display("FAIL misal_read_after got=%h/%h exp=11111111/6", p0_rd_data, xfer_count); end
  endtask

  task automatic test_reset_mid_op();
    int bad;
    @(negedge clk);
    p1_addr = 32'h24; p1_wr_data = 32'hA5A5A5A5; p1_wr_ena = 1'b1; p1_req = 1'b1; #1;
    checks++; if ({p1_gnt, p0_gnt} !== 2'b10) begin failures++; $display("FAIL rstmid_gnt got=%b exp=10", {p1_gnt, p0_gnt}); end
    @(negedge clk);
    p1_req = 1'b0; p1_wr_ena = 1'b0; rst = 1'b1; #1;
    checks++; if (mem_wr_ena !== 1'b0) begin failures++; $display("FAIL rstmid_wr_ena got=%b exp=0", mem_wr_ena); end
    @(negedge clk);
    rst = 1'b0;
    checks++; if (dut.r_state !== S_IDLE) begin failures++; $display("FAIL rstmid_state got=%0d exp=%0d", dut.r_state, S_IDLE); end
    checks++; if (xfer_count !== 32'd0 || p1_done !== 1'b0) begin failures++; $display("FAIL rstmid_abort got=%h/%b exp=0/0", xfer_count, p1_done); end
    bad = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (mem_wr_ena !== 1'b0 || p1_done !== 1'b0) bad++;
    end
    checks++; if (bad !== 0) begin failures++; $display("FAIL rstmid_quiet got=%0d exp=0", bad); end
    p0_addr = 32'h30; p0_wr_ena = 1'b0; rd_value = 32'h0BADF00D; p0_req = 1'b1; #1;
    checks++; if ({p1_gnt, p0_gnt} !== 2'b01) begin failures++; $display("FAIL rstmid_p0_gnt got=%b exp=01", {p1_gnt, p0_gnt}); end
    @(negedge clk); p0_req = 1'b0;
    @(negedge clk);
    checks++; if (p0_done !== 1'b1 || p0_rd_data !== 32'h0BADF00D) begin failures++; $display("FAIL rstmid_p0_done got=%b/%h exp=1/0badf00d", p0_done, p0_rd_data); end
    @(negedge clk);
    checks++; if (xfer_count !== 32'd1) begin failures++; $display("FAIL rstmid_p0_xfer got=%h exp=1", xfer_count); end
  endtask

  task automatic test_wrap();
    @(negedge clk);
    force dut.r_xfer_count = 32'hFFFFFFFF;
    #1;
    release dut.r_xfer_count;
    p0_addr = 32'h34; p0_wr_ena = 1'b0; rd_value = 32'h77777777; p0_req = 1'b1;
    @(negedge clk); p0_req = 1'b0;
    @(negedge clk);
    checks++; if (p0_done !== 1'b1) begin failures++; $display("FAIL wrap_done got=%b exp=1", p0_done); end
    @(negedge clk);
    checks++; if (xfer_count !== 32'h0) begin failures++; $display("FAIL wrap_xfer got=%h exp=00000000", xfer_count); end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_single_write();
    test_contention();
    test_misaligned();
    test_reset_mid_op();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
